// File: rtl/mem_stage.sv
// Memory-access pipeline stage: word load/store into a local array with a fixed multi-cycle latency.
// Optional MEM_BOUNDS_CHECK_EN: reject out-of-range accesses and flag them on addr_err.
module mem_stage #(
  parameter int          DEPTH       = 64,
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          WAIT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic [31:0] alu_res_in,
  input  logic [31:0] val_rm_in,
  input  logic [3:0]  dest_in,
  output logic        wb_en_out,
  output logic        mem_r_en_out,
  output logic [31:0] alu_res_out,
  output logic [3:0]  dest_out,
  output logic [31:0] mem_data,
  output logic        ready,
  output logic        addr_err,
  output logic [1:0]  state_o
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

  // State encoding is visible on state_o: 0 idle, 1 busy, 2 done.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      wdata_q;
  logic             we_q;
  logic [31:0]      mem_data_q;
  logic [31:0]      offset, word;
  logic [31:0]      rd_word;
  logic             wr_ok;
  logic             req, commit;

  logic [31:0] mem [DEPTH];

  assign wb_en_out    = wb_en_in;
  assign mem_r_en_out = mem_r_en_in;
  assign alu_res_out  = alu_res_in;
  assign dest_out     = dest_in;

  assign req    = mem_r_en_in | mem_w_en_in;
  assign offset = alu_res_in - BASE_ADDR;
  assign word   = offset >> 2;
  assign idx_d  = IDX_W'(word);
  assign commit = (state_q == S_BUSY) && (cnt_q == '0);

  assign ready    = (state_q == S_DONE) | ((state_q == S_IDLE) & ~req);
  assign mem_data = mem_data_q;
  assign state_o  = state_q;

`ifdef MEM_BOUNDS_CHECK_EN
  logic in_range, in_range_q, addr_err_q;

  assign in_range = (alu_res_in >= BASE_ADDR) && (word < 32'(DEPTH));
  assign rd_word  = in_range_q ? mem[idx_q] : '0;
  assign wr_ok    = in_range_q;
  assign addr_err = addr_err_q;

  // The flag is raised on the commit edge, so it is high exactly in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_range_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE && req) in_range_q <= in_range;
      addr_err_q <= commit & ~in_range_q;
    end
  end
`else
  assign rd_word  = mem[idx_q];
  assign wr_ok    = 1'b1;
  assign addr_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (req) begin
        state_d = S_BUSY;
        cnt_d   = CNT_INIT;
      end
      S_BUSY: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      mem_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Only the latched copies drive the access, so inputs may wander while busy.
      if (state_q == S_IDLE && req) begin
        idx_q   <= idx_d;
        wdata_q <= val_rm_in;
        we_q    <= mem_w_en_in;
      end
      if (commit) mem_data_q <= rd_word;
    end
  end

  // Array is deliberately not reset; a reset while busy never reaches the commit edge.
  always_ff @(posedge clk) begin
    if (!rst && commit && we_q && wr_ok) mem[idx_q] <= wdata_q;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: transaction-level timing/memory model plus a per-cycle compare process.
module tb_mem_stage;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'd1024;
  localparam int          WAIT  = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_en_in = 1'b0, mem_r_en_in = 1'b0, mem_w_en_in = 1'b0;
  logic [31:0] alu_res_in = '0, val_rm_in = '0;
  logic [3:0]  dest_in = '0;
  logic        wb_en_out, mem_r_en_out, ready, addr_err;
  logic [31:0] alu_res_out, mem_data;
  logic [3:0]  dest_out;
  logic [1:0]  state_o;

  always #5 clk = ~clk;

  mem_stage #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(WAIT)) dut (
    .clk(clk), .rst(rst),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .alu_res_in(alu_res_in), .val_rm_in(val_rm_in), .dest_in(dest_in),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .alu_res_out(alu_res_out),
    .dest_out(dest_out), .mem_data(mem_data), .ready(ready), .addr_err(addr_err),
    .state_o(state_o)
  );

  // ---------------- scoreboard / model state ----------------
  int          n_checks = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          issue_cyc = 0;
  bit          in_acc = 1'b0;
  logic [31:0] exp_q[$];
  logic        err_q[$];
  logic [31:0] exp_md = '0;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] dut_done_data = '0;
  logic        dut_done_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference address map: word offset from BASE, wrapped or bounds-checked.
  function automatic void map_addr(input logic [31:0] a, output int idx, output bit inr);
    logic [31:0] w;
    w   = (a - BASE) / 4;
    idx = int'(w % 32'(DEPTH));
`ifdef MEM_BOUNDS_CHECK_EN
    inr = (a >= BASE) && (w < 32'(DEPTH));
`else
    inr = 1'b1;
`endif
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin : compare
    int  k;
    bit  done;
    logic exp_err;
    done    = 1'b0;
    exp_err = 1'b0;
    chk("wb_en_pass", 32'(wb_en_out), 32'(wb_en_in));
    chk("mem_r_en_pass", 32'(mem_r_en_out), 32'(mem_r_en_in));
    chk("alu_res_pass", alu_res_out, alu_res_in);
    chk("dest_pass", 32'(dest_out), 32'(dest_in));
    if (rst) begin
      exp_md = '0;
      chk("rst_ready", 32'(ready), 32'(!(mem_r_en_in | mem_w_en_in)));
      chk("rst_mem_data", mem_data, 32'h0);
      chk("rst_addr_err", 32'(addr_err), 32'h0);
      chk("rst_state", 32'(state_o), 32'h0);
    end else begin
      if (in_acc) begin
        k = cyc - issue_cyc;
        done = (k == WAIT + 1);
        chk("acc_ready", 32'(ready), 32'(done));
        if (k == 0) chk("acc_issue_state", 32'(state_o), 32'h0);
        if (done) begin
          if (exp_q.size() == 0 || err_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL exp_q_empty: got empty queue expected an entry");
          end else begin
            exp_md  = exp_q.pop_front();
            exp_err = err_q.pop_front();
          end
          dut_done_data = mem_data;
          dut_done_err  = addr_err;
        end
      end else begin
        chk("idle_ready", 32'(ready), 32'(!(mem_r_en_in | mem_w_en_in)));
        chk("idle_state", 32'(state_o), 32'h0);
      end
      chk("mem_data", mem_data, exp_md);
      chk("addr_err", 32'(addr_err), 32'(exp_err));
    end
  end

  // ---------------- driver tasks (entered and left at posedge+1) ----------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      mem_r_en_in = 1'b0;
      mem_w_en_in = 1'b0;
      wb_en_in    = 1'($urandom);
      alu_res_in  = $urandom;
      dest_in     = 4'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic access(input logic re, input logic we, input logic [31:0] addr,
                        input logic [31:0] data, input bit wander);
    int idx;
    bit inr;
    mem_r_en_in = re;
    mem_w_en_in = we;
    alu_res_in  = addr;
    val_rm_in   = data;
    wb_en_in    = 1'($urandom);
    dest_in     = 4'($urandom);
    map_addr(addr, idx, inr);
    exp_q.push_back(inr ? model_mem[idx] : 32'h0);
`ifdef MEM_BOUNDS_CHECK_EN
    err_q.push_back(!inr);
`else
    err_q.push_back(1'b0);
`endif
    if (we && inr) model_mem[idx] = data;
    issue_cyc = cyc;
    in_acc    = 1'b1;
    for (int i = 0; i < WAIT + 2; i++) begin
      @(posedge clk); #1;
      if (wander && i < WAIT) begin
        alu_res_in  = addr + 32'd4;
        val_rm_in   = $urandom;
        mem_r_en_in = 1'($urandom);
        mem_w_en_in = 1'($urandom);
      end
    end
    in_acc      = 1'b0;
    mem_r_en_in = 1'b0;
    mem_w_en_in = 1'b0;
  endtask

  // Store that is cut off by reset in its second busy cycle; the model memory is left untouched.
  task automatic store_with_reset(input logic [31:0] addr, input logic [31:0] data);
    mem_r_en_in = 1'b0;
    mem_w_en_in = 1'b1;
    alu_res_in  = addr;
    val_rm_in   = data;
    issue_cyc   = cyc;
    in_acc      = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_acc      = 1'b0;
    mem_w_en_in = 1'b0;
    rst         = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected run to finish");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin : main
    logic [31:0] fillv, a;
    int kind;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // Fill every word so later loads have a known expectation.
    for (int i = 0; i < DEPTH; i++) begin
      fillv = (i == 2) ? 32'h0 : (i == 4) ? 32'hA5A5A5A5 : $urandom;
      access(1'b0, 1'b1, BASE + 32'(4 * i), fillv, 1'b0);
    end

    // Basic store / load.
    access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b0);
    access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0);
    chk("lit_load_1028", dut_done_data, 32'hDEADBEEF);

    // Non-memory instruction passes through with no stall.
    mem_r_en_in = 1'b0;
    mem_w_en_in = 1'b0;
    alu_res_in  = 32'h55;
    dest_in     = 4'd3;
    @(negedge clk);
    chk("lit_nonmem_ready", 32'(ready), 32'h1);
    chk("lit_nonmem_alu", alu_res_out, 32'h55);
    chk("lit_nonmem_dest", 32'(dest_out), 32'h3);
    @(posedge clk); #1;

    // Reset during busy discards the pending store.
    store_with_reset(32'd1032, 32'h12345678);
    access(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0);
    chk("lit_load_after_rst", dut_done_data, 32'h0);

    // Inputs wander during busy; only the latched access counts.
    access(1'b0, 1'b1, 32'd1032, 32'h12345678, 1'b1);
    access(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0);
    chk("lit_load_1032", dut_done_data, 32'h12345678);
    access(1'b1, 1'b0, 32'd1036, 32'h0, 1'b0);

    // Both enables: behaves as a store, returns the old word.
    access(1'b1, 1'b1, 32'd1040, 32'h11111111, 1'b0);
    chk("lit_both_old", dut_done_data, 32'hA5A5A5A5);
    access(1'b1, 1'b0, 32'd1040, 32'h0, 1'b0);
    chk("lit_both_new", dut_done_data, 32'h11111111);

    // One past the end of the array.
    access(1'b0, 1'b1, 32'd1280, 32'hCAFEF00D, 1'b0);
`ifdef MEM_BOUNDS_CHECK_EN
    chk("lit_oob_err", 32'(dut_done_err), 32'h1);
    access(1'b1, 1'b0, 32'd1280, 32'h0, 1'b0);
    chk("lit_oob_load", dut_done_data, 32'h0);
    access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);
`else
    chk("lit_wrap_err", 32'(dut_done_err), 32'h0);
    access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);
    chk("lit_wrap_load", dut_done_data, 32'hCAFEF00D);
`endif

    // Randomized mix of idle cycles, loads, stores and combined enables.
    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 4);
      if ($urandom_range(0, 7) == 0)
        a = BASE - 32'd64 + 32'($urandom_range(0, 4 * DEPTH + 127));
      else
        a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
      case (kind)
        0:       idle($urandom_range(1, 3));
        1:       access(1'b1, 1'b0, a, $urandom, $urandom_range(0, 3) == 0);
        3:       access(1'b1, 1'b1, a, $urandom, $urandom_range(0, 3) == 0);
        default: access(1'b0, 1'b1, a, $urandom, $urandom_range(0, 3) == 0);
      endcase
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
